// File: rtl/enum_stream_monitor_pkg.sv
// Shared types for the enum stream monitor: the raw byte carried on the input,
// the legal enum encodings, the forwarded record and the order-check states.
package enum_stream_monitor_pkg;

  // Raw input byte. It can carry encodings outside the enum.
  typedef logic [7:0] alias_t;

  // Legal encodings. Anything above THREE is illegal and gets dropped.
  typedef enum logic [7:0] {
    ONE   = 8'd0,
    TWO   = 8'd1,
    THREE = 8'd2
  } enum_t;

  // Record forwarded downstream. x holds the enum encoding.
  typedef struct packed {
    enum_t x;
  } struct_t;

  // Highest legal encoding.
  localparam enum_t ENUM_LAST = THREE;

  // Order-check states. EXP_ANY only exists between reset and the first legal value.
  typedef enum logic [1:0] {
    EXP_ANY,
    EXP_ONE,
    EXP_TWO,
    EXP_THREE
  } seq_state_t;

  // Expected state after legal value v. It follows the received value, so the
  // checker resynchronises after an error.
  function automatic seq_state_t next_exp(enum_t v);
    seq_state_t s;
    case (v)
      ONE:     s = EXP_TWO;
      TWO:     s = EXP_THREE;
      default: s = EXP_ONE;
    endcase
    return s;
  endfunction

  // True when legal value v is acceptable in state s.
  function automatic logic order_ok(seq_state_t s, enum_t v);
    logic ok;
    case (s)
      EXP_ONE:   ok = (v == ONE);
      EXP_TWO:   ok = (v == TWO);
      EXP_THREE: ok = (v == THREE);
      default:   ok = 1'b1;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/enum_stream_monitor_fifo.sv
// Small synchronous FIFO of struct_t records.
// The head is read straight from storage, so there is no input-to-output bypass.
// A pushed entry becomes visible the cycle after the push.
module enum_fifo
  import enum_stream_monitor_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    push,
  input  struct_t push_data,
  input  logic    pop,
  output struct_t head,
  output logic    full,
  output logic    empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  struct_t         mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;

  logic do_push;
  logic do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Storage write. Storage is cleared on reset so the head reads 0 while empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy update. Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/enum_stream_monitor.sv
// Consumer of the enum stream. It drops illegal encodings, checks the cyclic
// order ONE->TWO->THREE->ONE, keeps per-value counters, and forwards legal
// values through a small FIFO.
//
// Handshake, on both sides: a transfer happens on a rising edge where valid
// and ready are both high. valid never depends on ready. in_ready depends only
// on registered FIFO state, so a pop cannot re-open the input in the same cycle.
module enum_stream_monitor
  import enum_stream_monitor_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  alias_t           in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output struct_t          out_data,
  input  logic             clr_stats,
  output logic [CNT_W-1:0] cnt_one,
  output logic [CNT_W-1:0] cnt_two,
  output logic [CNT_W-1:0] cnt_three,
  output logic [CNT_W-1:0] illegal_cnt,
  output logic             seq_err,
  output logic [1:0]       dbg_seq_state
);

  localparam logic [1:0]       ST_ANY  = EXP_ANY;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_INC = {{(CNT_W-1){1'b0}}, 1'b1};

  logic       full;
  logic       empty;
  logic       in_fire;
  logic       legal;
  logic       push;
  logic       pop;
  logic       bad_order;
  enum_t      in_val;
  struct_t    push_rec;
  logic [1:0] state_q;

  assign in_val    = enum_t'(in_data);
  assign legal     = (in_data <= ENUM_LAST);
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign in_fire   = in_valid && in_ready;
  assign push      = in_fire && legal;
  assign pop       = out_valid && out_ready;
  assign bad_order = push && !order_ok(seq_state_t'(state_q), in_val);
  assign push_rec  = '{x: in_val};

  assign dbg_seq_state = state_q;

  enum_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_rec),
    .pop       (pop),
    .head      (out_data),
    .full      (full),
    .empty     (empty)
  );

  // Order FSM. It follows every legal value, including out-of-order ones,
  // and ignores illegal values. clr_stats does not affect it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_ANY;
    end else if (push) begin
      state_q <= next_exp(in_val);
    end
  end

  // Sticky order error. A clear in the same cycle as a new error wins.
  always_ff @(posedge clk) begin
    if (rst || clr_stats) begin
      seq_err <= 1'b0;
    end else if (bad_order) begin
      seq_err <= 1'b1;
    end
  end

  // Saturating per-kind counters. A clear in the same cycle as an increment wins.
  always_ff @(posedge clk) begin
    if (rst || clr_stats) begin
      cnt_one     <= '0;
      cnt_two     <= '0;
      cnt_three   <= '0;
      illegal_cnt <= '0;
    end else begin
      if (push && (in_val == ONE) && (cnt_one != CNT_MAX)) begin
        cnt_one <= cnt_one + CNT_INC;
      end
      if (push && (in_val == TWO) && (cnt_two != CNT_MAX)) begin
        cnt_two <= cnt_two + CNT_INC;
      end
      if (push && (in_val == THREE) && (cnt_three != CNT_MAX)) begin
        cnt_three <= cnt_three + CNT_INC;
      end
      if (in_fire && !legal && (illegal_cnt != CNT_MAX)) begin
        illegal_cnt <= illegal_cnt + CNT_INC;
      end
    end
  end

endmodule
